// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: walks register addresses FIRST_REG..M-1 through one read port and streams
// (address, value) pairs on valid/ready. Optional trailing XOR checksum word: REG_DUMP_CHECKSUM_EN.
module reg_dump_ctrl #(
  parameter int M         = 32,
  parameter int N         = 8,
  parameter int FIRST_REG = 1
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(M)-1:0] rd_addr,
  input  logic [N-1:0]         rd_data,
  output logic [$clog2(M)-1:0] out_addr,
  output logic [N-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [2:0]           dbg_state
);
  localparam int AW = $clog2(M);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(FIRST_REG);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(M - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, SEND = 3'd2, CSUM = 3'd3, DONE = 3'd4
  } state_t;
  logic [N-1:0] acc;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, SEND = 3'd2, DONE = 3'd4
  } state_t;
`endif

  state_t state;

  assign dbg_state = state;

  // Output handshake: a word transfers on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_addr/out_data/out_last do not change,
  // and out_ready has no effect while out_valid is low.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr   <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_addr <= FIRST_ADDR;
            busy    <= 1'b1;
            state   <= LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
            acc     <= '0;
`endif
          end
        end
        // rd_data is a combinational read of rd_addr, so it is valid in this cycle.
        LOAD: begin
          out_data  <= rd_data;
          out_addr  <= rd_addr;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= (rd_addr == LAST_ADDR);
`endif
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
            acc <= acc ^ out_data;
`endif
            if (out_addr == LAST_ADDR) begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Checksum word follows back-to-back; out_valid stays high.
              out_data <= acc ^ out_data;
              out_addr <= '0;
              out_last <= 1'b1;
              state    <= CSUM;
`else
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
`endif
            end else begin
              out_valid <= 1'b0;
              rd_addr   <= rd_addr + 1'b1;
              state     <= LOAD;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
